cache_fill_ctl: RTL and testbench
=================================

Name: cache_fill_ctl

Overview:
- Sequences all cache-line traffic between the CPU pipeline's caches and the 32-bit system memory bus.
- Three requesters share one bus master port: icache line fill, dcache dirty-victim writeback, dcache line fill.
- Runs each transaction as a single-grant burst and writes fill data back into the requesting cache's line RAM.
- Pipeline stall logic holds `icfill`/`dcfill` high and waits for this block's done pulses.

Parameters:
- IWORDS, 8, 32-bit words per icache line (32 B).
- DWORDS, 4, 32-bit words per dcache line (16 B).
- PAW, 32, physical address width.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- ic_req  in  1  icache fill request; held until ic_done.
- ic_pa  in  PAW  physical address of the missing instruction.
- ic_we  out  1  write strobe into icache line RAM.
- ic_widx  out  3  word index within the icache line.
- ic_done  out  1  one-cycle pulse: icache line complete.
- dc_req  in  1  dcache fill request; held until dc_done.
- dc_pa  in  PAW  physical address of the missing data.
- dc_dirty  in  1  victim line is dirty; sampled with dc_req at acceptance.
- dc_vpa  in  PAW  victim line physical address.
- dc_ridx  out  2  victim word index being read.
- dc_rdata  in  32  victim word; combinational from dc_ridx.
- dc_we  out  1  write strobe into dcache line RAM.
- dc_widx  out  2  word index within the dcache line.
- dc_done  out  1  one-cycle pulse: writeback (if any) and fill complete.
- fill_data  out  32  fill word, shared by both caches.
- m_req  out  1  bus request.
- m_wr  out  1  1 = write burst.
- m_addr  out  PAW  line-aligned burst address.
- m_len  out  4  beats in the burst minus 1.
- m_gnt  in  1  one-cycle grant; accepts the request.
- m_rvalid  in  1  read beat valid on m_rdata.
- m_rdata  in  32  read data.
- m_wdata  out  32  write data.
- m_wready  in  1  write beat accepted this cycle.

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, fairness flag 0. Asserting rstn low mid-burst aborts immediately; no done pulse is issued.
- States: IDLE, IRD, DWB, DRD, DONE.
- Arbitration (IDLE only): the winner is chosen in the cycle it is seen.
  - dc_req wins over ic_req unless ic_starve=1.
  - ic_starve sets when a dc transaction is accepted while ic_req=1.
  - ic_starve clears when IRD is entered.
- IDLE -> DWB when dc is accepted with dc_dirty=1.
- IDLE -> DRD when dc is accepted with dc_dirty=0.
- IDLE -> IRD when ic is accepted.
- Request phase, on entry to each burst state:
  - m_req=1; m_addr = line-aligned address (low log2(words*4) bits zeroed).
  - m_len: IWORDS-1 for IRD, DWORDS-1 for DWB/DRD.
  - m_wr=1 only in DWB.
  - All stay stable until m_gnt; m_req drops the cycle after m_gnt.
- IRD/DRD data phase:
  - Each m_rvalid beat: fill_data=m_rdata, the cache's we=1, widx=beat counter, counter increments. No other cycle strobes we.
  - After the last beat (counter = words-1): IRD -> DONE(ic); DRD -> DONE(dc).
- DWB data phase:
  - dc_ridx = counter; m_wdata = dc_rdata.
  - Counter advances on m_wready.
  - After the last accepted beat: counter reset, -> DRD with a new request.
- DONE: the matching done pulse is high for exactly one cycle, then -> IDLE.
  - Requester drops its req in the cycle after done. A req still high in the IDLE cycle after DONE counts as a new request.
- Ignored inputs:
  - m_rvalid in DWB or IDLE.
  - m_wready outside DWB.
  - Extra beats beyond m_len.
- Latency: request-to-m_req is 1 cycle (IDLE register). Fill done arrives 1 cycle after the final beat.
- Requests arriving during a burst wait; at most one transaction is outstanding.

Decomposition:
- Shared package (cpuconst.vh) holds:
  - state encodings;
  - IWORDS/DWORDS defaults;
  - line-offset widths.
- Optional sub-module cache_fill_beat: beat counter plus last-beat compare, instanced once and reloaded per burst.
- All other logic stays in one module.

Test Plan:
- Clean icache miss:
  - Stimulus: ic_req, ic_pa=0x0000_1234; grant after 3 cycles; 8 read beats 0xA0..0xA7, no gaps.
  - Response: m_addr=0x0000_1220, m_len=7, m_wr=0; ic_we with widx 0..7 carrying 0xA0..0xA7; ic_done one cycle after the last beat.
- Dirty dcache miss:
  - Stimulus: dc_pa=0x8010, dc_vpa=0x4010, dc_dirty=1; m_wready toggling.
  - Response: write burst to 0x4010 with m_len=3 and words 0..3 in order, then read burst to 0x8010; dc_done only after the fill.
- Simultaneous ic_req and dc_req:
  - Stimulus: both raised together; dc re-requests immediately after its dc_done.
  - Response: dc served first; IRD taken next (starve flag); dc served after that.
- Gapped read beats:
  - Stimulus: m_rvalid with idle gaps, plus stray m_rvalid before the grant.
  - Response: no we strobe on gaps or stray beats; widx strictly 0..N-1.
- Reset mid-DWB:
  - Stimulus: rstn asserted after beat 1 of a writeback.
  - Response: all outputs 0 asynchronously; no dc_done; after release, a held dc_req restarts from DWB beat 0.

Source files
------------

// File: rtl/cache_fill_ctl_pkg.sv
// cache_fill_ctl_pkg: controller states and default line geometry shared by the fill controller.
package cache_fill_ctl_pkg;
  typedef enum logic [2:0] {IDLE, IRD, DWB, DRD, DONE} state_t;
  localparam int IWORDS_D = 8;
  localparam int DWORDS_D = 4;
  localparam int PAW_D = 32;
  localparam int IOFF_D = $clog2(IWORDS_D * 4);
  localparam int DOFF_D = $clog2(DWORDS_D * 4);
endpackage

// File: rtl/cache_fill_ctl_beat.sv
// cache_fill_ctl_beat: burst beat counter with last-beat compare, cleared at the start of every burst.
module cache_fill_ctl_beat #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
  output logic         last
);
  assign last = cnt == lim;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cache_fill_ctl.sv
// cache_fill_ctl: arbitrates icache fill, dcache writeback and dcache fill onto one burst bus master.
module cache_fill_ctl
  import cache_fill_ctl_pkg::*;
#(
  parameter int IWORDS = IWORDS_D,
  parameter int DWORDS = DWORDS_D,
  parameter int PAW    = PAW_D
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ic_req,
  input  logic [PAW-1:0]            ic_pa,
  output logic                      ic_we,
  output logic [$clog2(IWORDS)-1:0] ic_widx,
  output logic                      ic_done,
  input  logic                      dc_req,
  input  logic [PAW-1:0]            dc_pa,
  input  logic                      dc_dirty,
  input  logic [PAW-1:0]            dc_vpa,
  output logic [$clog2(DWORDS)-1:0] dc_ridx,
  input  logic [31:0]               dc_rdata,
  output logic                      dc_we,
  output logic [$clog2(DWORDS)-1:0] dc_widx,
  output logic                      dc_done,
  output logic [31:0]               fill_data,
  output logic                      m_req,
  output logic                      m_wr,
  output logic [PAW-1:0]            m_addr,
  output logic [3:0]                m_len,
  input  logic                      m_gnt,
  input  logic                      m_rvalid,
  input  logic [31:0]               m_rdata,
  output logic [31:0]               m_wdata,
  input  logic                      m_wready
);
  localparam int CW = $clog2(IWORDS);
  localparam int DW = $clog2(DWORDS);
  localparam logic [PAW-1:0] IMASK = ~PAW'((1 << $clog2(IWORDS * 4)) - 1);
  localparam logic [PAW-1:0] DMASK = ~PAW'((1 << $clog2(DWORDS * 4)) - 1);
  state_t state;
  logic ic_starve, take_ic, take_dc, rbeat, wbeat, last;
  logic [CW-1:0] cnt, lim;
  logic [PAW-1:0] fill_pa;
  assign take_ic = ic_req && (!dc_req || ic_starve);
  assign take_dc = dc_req && !take_ic;
  // Beats only count once the request has been granted, so stray strobes during the request phase are dropped.
  assign rbeat = (state == IRD || state == DRD) && !m_req && m_rvalid;
  assign wbeat = state == DWB && !m_req && m_wready;
  assign lim = state == IRD ? CW'(IWORDS - 1) : CW'(DWORDS - 1);
  assign dc_ridx = state == DWB ? cnt[DW-1:0] : '0;
  assign m_wdata = (state == DWB && !m_req) ? dc_rdata : '0;
  cache_fill_ctl_beat #(.W(CW)) u_beat (
    .clk (clk),
    .rstn(rstn),
    .clr (state == IDLE || (wbeat && last)),
    .inc (rbeat || wbeat),
    .lim (lim),
    .cnt (cnt),
    .last(last)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ic_starve <= 1'b0;
      fill_pa <= '0;
      m_req <= 1'b0;
      m_wr <= 1'b0;
      m_addr <= '0;
      m_len <= '0;
      ic_we <= 1'b0;
      ic_widx <= '0;
      ic_done <= 1'b0;
      dc_we <= 1'b0;
      dc_widx <= '0;
      dc_done <= 1'b0;
      fill_data <= '0;
    end else begin
      ic_we <= 1'b0;
      dc_we <= 1'b0;
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      if (m_req && m_gnt) m_req <= 1'b0;
      if (rbeat) fill_data <= m_rdata;
      case (state)
        IDLE: begin
          if (take_ic) begin
            state <= IRD;
            ic_starve <= 1'b0;
            m_req <= 1'b1;
            m_wr <= 1'b0;
            m_addr <= ic_pa & IMASK;
            m_len <= 4'(IWORDS - 1);
          end else if (take_dc) begin
            state <= dc_dirty ? DWB : DRD;
            if (ic_req) ic_starve <= 1'b1;
            m_req <= 1'b1;
            m_wr <= dc_dirty;
            m_addr <= dc_dirty ? dc_vpa & DMASK : dc_pa & DMASK;
            m_len <= 4'(DWORDS - 1);
            fill_pa <= dc_pa & DMASK;
          end
        end
        IRD: if (rbeat) begin
          ic_we <= 1'b1;
          ic_widx <= cnt;
          if (last) begin
            state <= DONE;
            ic_done <= 1'b1;
          end
        end
        DRD: if (rbeat) begin
          dc_we <= 1'b1;
          dc_widx <= cnt[DW-1:0];
          if (last) begin
            state <= DONE;
            dc_done <= 1'b1;
          end
        end
        // Writeback chains straight into the fill of the same dcache line.
        DWB: if (wbeat && last) begin
          state <= DRD;
          m_req <= 1'b1;
          m_wr <= 1'b0;
          m_addr <= fill_pa;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_ctl.sv
// tb_cache_fill_ctl: scoreboard bench driving bus and cache sides of cache_fill_ctl.
module tb_cache_fill_ctl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, ic_req, ic_we, ic_done, dc_req, dc_dirty, dc_we, dc_done;
  logic m_req, m_wr, m_gnt, m_rvalid, m_wready;
  logic [31:0] ic_pa, dc_pa, dc_vpa, dc_rdata, fill_data, m_addr, m_rdata, m_wdata;
  logic [2:0] ic_widx;
  logic [1:0] dc_ridx, dc_widx;
  logic [3:0] m_len;
  logic [31:0] victim [4];
  logic [112:0] outs;
  int total = 0, bad = 0, ic_dones = 0, dc_dones = 0;
  typedef struct packed {logic wr; logic [31:0] addr; logic [3:0] len;} bus_t;
  bus_t exp_bus[$];
  logic [34:0] exp_ic[$];
  logic [33:0] exp_dc[$];
  assign dc_rdata = victim[dc_ridx];
  assign outs = {ic_we, ic_widx, ic_done, dc_ridx, dc_we, dc_widx, dc_done, fill_data,
                 m_req, m_wr, m_addr, m_len, m_wdata};
  cache_fill_ctl dut (
    .clk(clk), .rstn(rstn),
    .ic_req(ic_req), .ic_pa(ic_pa), .ic_we(ic_we), .ic_widx(ic_widx), .ic_done(ic_done),
    .dc_req(dc_req), .dc_pa(dc_pa), .dc_dirty(dc_dirty), .dc_vpa(dc_vpa), .dc_ridx(dc_ridx),
    .dc_rdata(dc_rdata), .dc_we(dc_we), .dc_widx(dc_widx), .dc_done(dc_done),
    .fill_data(fill_data), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_wdata(m_wdata), .m_wready(m_wready)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (rstn) begin
    if (ic_we) begin
      if (exp_ic.size() == 0) chk("ic_we_stray", ic_we, 1'b0);
      else chk("ic_fill", {ic_widx, fill_data}, exp_ic.pop_front());
    end
    if (dc_we) begin
      if (exp_dc.size() == 0) chk("dc_we_stray", dc_we, 1'b0);
      else chk("dc_fill", {dc_widx, fill_data}, exp_dc.pop_front());
    end
    if (ic_done) ic_dones++;
    if (dc_done) dc_dones++;
  end
  // Acts as the bus slave for one burst: grant after gd cycles, then data with optional gaps.
  task automatic serve(input bit ic, input logic [31:0] base, input int gd, input bit gap, input bit stray);
    bus_t e;
    int n = 0;
    e = exp_bus.pop_front();
    while (!m_req && n < 40) begin
      tick;
      n++;
    end
    chk("bus_req", {m_wr, m_addr, m_len}, e);
    for (int k = 0; k < gd; k++) begin
      m_rvalid = stray;
      m_wready = stray;
      m_rdata = 32'hdead_0000 + 32'(k);
      tick;
      chk("req_hold", {m_req, m_wr, m_addr, m_len}, {1'b1, e});
    end
    m_rvalid = 1'b0;
    m_wready = 1'b0;
    m_gnt = 1'b1;
    tick;
    m_gnt = 1'b0;
    chk("req_drop", m_req, 1'b0);
    for (int i = 0; i <= int'(e.len); i++) begin
      if (gap && i[0]) begin
        m_rvalid = 1'b0;
        m_wready = 1'b0;
        m_rdata = 32'hbad0_0000;
        tick;
      end
      if (e.wr) begin
        m_wready = 1'b1;
        #1;
        chk("wb_word", {dc_ridx, m_wdata}, {i[1:0], victim[i[1:0]]});
        tick;
        m_wready = 1'b0;
      end else begin
        m_rvalid = 1'b1;
        m_rdata = base + 32'(i);
        if (ic) exp_ic.push_back({3'(i), base + 32'(i)});
        else exp_dc.push_back({2'(i), base + 32'(i)});
        tick;
      end
    end
    m_rvalid = 1'b0;
  endtask
  task automatic finish(input bit ic, input int n_exp);
    chk(ic ? "ic_done" : "dc_done", ic ? ic_done : dc_done, 1'b1);
    tick;
    chk("done_pulse", {ic_done, dc_done}, 2'b00);
    chk("done_count", ic ? ic_dones : dc_dones, n_exp);
    chk("fill_q_empty", exp_ic.size() + exp_dc.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end
  initial begin
    rstn = 1'b0;
    {ic_req, dc_req, dc_dirty, m_gnt, m_rvalid, m_wready} = '0;
    {ic_pa, dc_pa, dc_vpa, m_rdata} = '0;
    victim = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    repeat (2) tick;
    chk("reset_out", outs, '0);
    rstn = 1'b1;
    tick;
    // clean icache miss
    ic_pa = 32'h0000_1234;
    exp_bus.push_back('{1'b0, 32'h0000_1220, 4'd7});
    ic_req = 1'b1;
    tick;
    chk("req_latency", m_req, 1'b1);
    serve(1'b1, 32'hA0, 3, 1'b0, 1'b0);
    finish(1'b1, 1);
    ic_req = 1'b0;
    tick;
    // dirty dcache miss with toggling m_wready
    dc_pa = 32'h0000_8010;
    dc_vpa = 32'h0000_4010;
    dc_dirty = 1'b1;
    dc_req = 1'b1;
    exp_bus.push_back('{1'b1, 32'h0000_4010, 4'd3});
    exp_bus.push_back('{1'b0, 32'h0000_8010, 4'd3});
    serve(1'b0, 32'h0, 2, 1'b1, 1'b0);
    chk("no_early_dc_done", {dc_done, 32'(dc_dones)}, {1'b0, 32'd0});
    serve(1'b0, 32'hC0, 1, 1'b0, 1'b0);
    finish(1'b0, 1);
    dc_req = 1'b0;
    dc_dirty = 1'b0;
    tick;
    // simultaneous requests: dc, then starved ic, then dc again
    ic_pa = 32'h0000_2040;
    dc_pa = 32'h0000_9004;
    exp_bus.push_back('{1'b0, 32'h0000_9000, 4'd3});
    exp_bus.push_back('{1'b0, 32'h0000_2040, 4'd7});
    exp_bus.push_back('{1'b0, 32'h0000_9120, 4'd3});
    ic_req = 1'b1;
    dc_req = 1'b1;
    serve(1'b0, 32'hD0, 1, 1'b0, 1'b0);
    finish(1'b0, 2);
    dc_pa = 32'h0000_9128;
    serve(1'b1, 32'hB0, 0, 1'b0, 1'b0);
    finish(1'b1, 2);
    ic_req = 1'b0;
    serve(1'b0, 32'hE0, 2, 1'b0, 1'b0);
    finish(1'b0, 3);
    dc_req = 1'b0;
    tick;
    // gapped beats, stray beats before grant and one beat past the burst
    ic_pa = 32'h0000_3FFC;
    exp_bus.push_back('{1'b0, 32'h0000_3FE0, 4'd7});
    m_rvalid = 1'b1;
    m_rdata = 32'h5555_5555;
    ic_req = 1'b1;
    tick;
    serve(1'b1, 32'h70, 2, 1'b1, 1'b1);
    m_rvalid = 1'b1;
    m_rdata = 32'hEE;
    finish(1'b1, 3);
    m_rvalid = 1'b0;
    ic_req = 1'b0;
    repeat (2) tick;
    // reset in the middle of a writeback
    victim = '{32'h0A0A_0000, 32'h0B0B_0001, 32'h0C0C_0002, 32'h0D0D_0003};
    dc_pa = 32'h0000_A000;
    dc_vpa = 32'h0000_5000;
    dc_dirty = 1'b1;
    dc_req = 1'b1;
    tick;
    chk("wb_req", {m_req, m_wr, m_addr}, {2'b11, 32'h0000_5000});
    m_gnt = 1'b1;
    tick;
    m_gnt = 1'b0;
    m_wready = 1'b1;
    repeat (2) tick;
    chk("wb_mid_idx", dc_ridx, 2'd2);
    #2 rstn = 1'b0;
    m_wready = 1'b0;
    #1 chk("async_reset_out", outs, '0);
    repeat (2) tick;
    chk("no_done_on_abort", dc_dones, 3);
    #3 rstn = 1'b1;
    exp_bus.push_back('{1'b1, 32'h0000_5000, 4'd3});
    exp_bus.push_back('{1'b0, 32'h0000_A000, 4'd3});
    serve(1'b0, 32'h0, 0, 1'b0, 1'b0);
    serve(1'b0, 32'h60, 1, 1'b0, 1'b0);
    finish(1'b0, 4);
    dc_req = 1'b0;
    dc_dirty = 1'b0;
    repeat (3) tick;
    chk("idle_after", {m_req, 32'(exp_bus.size())}, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
